// File: rtl/touch_event_filter.sv
// touch_event_filter
// Debounces the pen-down level from the touch controller, averages raw
// digitizer samples over fixed windows and turns them into PRESS / MOVE /
// RELEASE events presented over a single-slot valid/ready output.
//
// Build option: define TOUCH_FILTER_MOVE_EN to build the MOVE detection
// (per-window comparison against the last reported position). Without it
// only PRESS and RELEASE are produced and RELEASE reports the PRESS position.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   touch_in   pen-down level
//   sample_stb one-cycle pulse, x_in/y_in carry a new sample
//   x_in/y_in  raw 12-bit coordinates
//   evt_valid  event slot occupied
//   evt_ready  consumer accepts the event
//   evt_type   01 PRESS, 10 MOVE, 11 RELEASE
//   evt_x/y    averaged 12-bit coordinates
//   drop_cnt   saturating count of dropped events
module touch_event_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000,
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned MOVE_THRESH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        touch_in,
    input  logic        sample_stb,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_type,
    output logic [11:0] evt_x,
    output logic [11:0] evt_y,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned COORD_W = 12;
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned ACC_W   = COORD_W + AVG_LOG2;
    localparam int unsigned SCNT_W  = AVG_LOG2;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       EVT_PRESS   = 2'b01;
    localparam logic [1:0]       EVT_MOVE    = 2'b10;
    localparam logic [1:0]       EVT_RELEASE = 2'b11;
    localparam logic [7:0]       DROP_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_DN,
        S_ACCUM,
        S_DOWN,
        S_DEB_UP
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc_x, acc_y;
    logic [SCNT_W-1:0]  scnt;
    logic [COORD_W-1:0] last_x, last_y;

    // Window arithmetic: sum including the current sample, truncating average
    logic [ACC_W-1:0]   sum_x_c, sum_y_c;
    logic [COORD_W-1:0] avg_x_c, avg_y_c;
    logic               win_done_c;
    logic               cnt_last_c;
    logic               move_hit_c;

    assign sum_x_c    = acc_x + ACC_W'(x_in);
    assign sum_y_c    = acc_y + ACC_W'(y_in);
    assign avg_x_c    = COORD_W'(sum_x_c >> AVG_LOG2);
    assign avg_y_c    = COORD_W'(sum_y_c >> AVG_LOG2);
    assign win_done_c = sample_stb && (&scnt);
    assign cnt_last_c = (cnt == CNT_LAST);

`ifdef TOUCH_FILTER_MOVE_EN
    // Per-axis |avg - last_pos| as 13-bit signed differences
    logic signed [COORD_W:0] dx_c, dy_c;
    logic        [COORD_W:0] adx_c, ady_c;

    assign dx_c  = $signed({1'b0, avg_x_c}) - $signed({1'b0, last_x});
    assign dy_c  = $signed({1'b0, avg_y_c}) - $signed({1'b0, last_y});
    assign adx_c = dx_c[COORD_W] ? (COORD_W+1)'(-dx_c) : (COORD_W+1)'(dx_c);
    assign ady_c = dy_c[COORD_W] ? (COORD_W+1)'(-dy_c) : (COORD_W+1)'(dy_c);
    assign move_hit_c = (adx_c >= (COORD_W+1)'(MOVE_THRESH)) ||
                        (ady_c >= (COORD_W+1)'(MOVE_THRESH));
`else
    assign move_hit_c = 1'b0;
`endif

    // Control strobes from the output decode
    logic               cnt_clr_c, cnt_inc_c;
    logic               acc_clr_c, acc_add_c;
    logic               pos_load_c;
    logic               emit_c;
    logic [1:0]         emit_type_c;
    logic [COORD_W-1:0] emit_x_c, emit_y_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (touch_in) state_nxt = S_DEB_DN;
            end
            S_DEB_DN: begin
                if (!touch_in)       state_nxt = S_IDLE;
                else if (cnt_last_c) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                // A completing strobe is honoured even if the pen lifts that cycle
                if (win_done_c)     state_nxt = S_DOWN;
                else if (!touch_in) state_nxt = S_IDLE;
            end
            S_DOWN: begin
                if (!touch_in) state_nxt = S_DEB_UP;
            end
            S_DEB_UP: begin
                if (touch_in)        state_nxt = S_DOWN;
                else if (cnt_last_c) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        cnt_clr_c   = 1'b0;
        cnt_inc_c   = 1'b0;
        acc_clr_c   = 1'b0;
        acc_add_c   = 1'b0;
        pos_load_c  = 1'b0;
        emit_c      = 1'b0;
        emit_type_c = 2'b00;
        emit_x_c    = '0;
        emit_y_c    = '0;
        case (state)
            S_IDLE: begin
                if (touch_in) cnt_clr_c = 1'b1;
            end
            S_DEB_DN: begin
                if (touch_in) begin
                    if (cnt_last_c) acc_clr_c = 1'b1;
                    else            cnt_inc_c = 1'b1;
                end
            end
            S_ACCUM: begin
                if (win_done_c) begin
                    emit_c      = 1'b1;
                    emit_type_c = EVT_PRESS;
                    emit_x_c    = avg_x_c;
                    emit_y_c    = avg_y_c;
                    pos_load_c  = 1'b1;
                    acc_clr_c   = 1'b1;
                end else begin
                    if (sample_stb) acc_add_c = 1'b1;
                    if (!touch_in)  acc_clr_c = 1'b1;
                end
            end
            S_DOWN: begin
                if (win_done_c) begin
                    acc_clr_c = 1'b1;
                    if (move_hit_c) begin
                        emit_c      = 1'b1;
                        emit_type_c = EVT_MOVE;
                        emit_x_c    = avg_x_c;
                        emit_y_c    = avg_y_c;
                        pos_load_c  = 1'b1;
                    end
                end else if (sample_stb) begin
                    acc_add_c = 1'b1;
                end
                // Pen lift discards any partial window
                if (!touch_in) begin
                    cnt_clr_c = 1'b1;
                    acc_clr_c = 1'b1;
                end
            end
            S_DEB_UP: begin
                if (touch_in) begin
                    acc_clr_c = 1'b1;
                end else if (cnt_last_c) begin
                    emit_c      = 1'b1;
                    emit_type_c = EVT_RELEASE;
                    emit_x_c    = last_x;
                    emit_y_c    = last_y;
                end else begin
                    cnt_inc_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counters, accumulators and last reported position
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc_x  <= '0;
            acc_y  <= '0;
            scnt   <= '0;
            last_x <= '0;
            last_y <= '0;
        end else begin
            if (cnt_clr_c)      cnt <= '0;
            else if (cnt_inc_c) cnt <= cnt + CNT_W'(1);

            if (acc_clr_c) begin
                acc_x <= '0;
                acc_y <= '0;
                scnt  <= '0;
            end else if (acc_add_c) begin
                acc_x <= sum_x_c;
                acc_y <= sum_y_c;
                scnt  <= scnt + SCNT_W'(1);
            end

            if (pos_load_c) begin
                last_x <= avg_x_c;
                last_y <= avg_y_c;
            end
        end
    end

    // Single-slot output with drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_type  <= 2'b00;
            evt_x     <= '0;
            evt_y     <= '0;
            drop_cnt  <= '0;
        end else if (emit_c) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_type  <= emit_type_c;
                evt_x     <= emit_x_c;
                evt_y     <= emit_y_c;
            end else begin
                // Slot blocked: either the held MOVE or the new event is lost
                if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
                if (emit_type_c != EVT_MOVE && evt_type == EVT_MOVE) begin
                    evt_type <= emit_type_c;
                    evt_x    <= emit_x_c;
                    evt_y    <= emit_y_c;
                end
            end
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_touch_event_filter.sv
module tb_touch_event_filter;

    logic        clk;
    logic        rst;
    logic        touch_in;
    logic        sample_stb;
    logic [11:0] x_in;
    logic [11:0] y_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_type;
    logic [11:0] evt_x;
    logic [11:0] evt_y;
    logic [7:0]  drop_cnt;

    typedef struct packed {
        logic [1:0]  t;
        logic [11:0] x;
        logic [11:0] y;
    } evt_t;

    evt_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    touch_event_filter #(
        .DEBOUNCE_CYCLES(4),
        .AVG_LOG2       (2),
        .MOVE_THRESH    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .touch_in  (touch_in),
        .sample_stb(sample_stb),
        .x_in      (x_in),
        .y_in      (y_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_x     (evt_x),
        .evt_y     (evt_y),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [11:0] xv, input logic [11:0] yv);
        sample_stb = 1'b1;
        x_in       = xv;
        y_in       = yv;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic win4(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [11:0] d,
                        input logic [11:0] yv);
        strobe(a, yv);
        strobe(b, yv);
        strobe(c, yv);
        strobe(d, yv);
    endtask

    task automatic push(input logic [1:0] t, input logic [11:0] xv, input logic [11:0] yv);
        evt_t e;
        e.t = t;
        e.x = xv;
        e.y = yv;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed transfer is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual type=%0d x=%0d y=%0d required=none",
                         evt_type, evt_x, evt_y);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                check("evt_type", int'(evt_type), int'(e.t));
                check("evt_x", int'(evt_x), int'(e.x));
                check("evt_y", int'(evt_y), int'(e.y));
            end
        end
    end

    int exp_drop;
    int last_x_exp;

    initial begin
        rst        = 1'b1;
        touch_in   = 1'b0;
        sample_stb = 1'b0;
        x_in       = '0;
        y_in       = '0;
        evt_ready  = 1'b1;
        tick(3);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_type", int'(evt_type), 0);
        check("rst_x", int'(evt_x), 0);
        check("rst_y", int'(evt_y), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        tick();

        // Glitch: two cycles high is shorter than the debounce
        touch_in = 1'b1;
        strobe(12'd11, 12'd22);
        strobe(12'd33, 12'd44);
        touch_in = 1'b0;
        strobe(12'd55, 12'd66);
        strobe(12'd77, 12'd88);
        tick(3);
        check("glitch_valid", int'(evt_valid), 0);
        check("glitch_drop", int'(drop_cnt), 0);

        // Press: average of 100,102,104,106 is 103
        touch_in = 1'b1;
        tick(6);
        push(2'b01, 12'd103, 12'd200);
        strobe(12'd100, 12'd200);
        strobe(12'd102, 12'd200);
        strobe(12'd104, 12'd200);
        check("press_early", int'(evt_valid), 0);
        strobe(12'd106, 12'd200);
        check("press_latency", int'(evt_valid), 1);
        tick(2);

        // Move windows
`ifdef TOUCH_FILTER_MOVE_EN
        push(2'b10, 12'd120, 12'd200);
        last_x_exp = 120;
`else
        last_x_exp = 103;
`endif
        win4(12'd120, 12'd120, 12'd120, 12'd120, 12'd200);
        tick(2);
        win4(12'd125, 12'd125, 12'd125, 12'd125, 12'd203);
        tick(2);

        // Short lift is ignored, long lift releases
        touch_in = 1'b0;
        tick(2);
        touch_in = 1'b1;
        tick(3);
        check("release_glitch", int'(evt_valid), 0);
        push(2'b11, 12'(last_x_exp), 12'd200);
        touch_in = 1'b0;
        tick(5);
        check("release_latency", int'(evt_valid), 1);
        tick(2);
        check("sb_drain_basic", exp_q.size(), 0);

        // Backpressure: held PRESS survives later events
        evt_ready = 1'b0;
        exp_drop  = 0;
        touch_in  = 1'b1;
        tick(6);
        push(2'b01, 12'd103, 12'd200);
        win4(12'd100, 12'd102, 12'd104, 12'd106, 12'd200);
        tick();
`ifdef TOUCH_FILTER_MOVE_EN
        win4(12'd120, 12'd120, 12'd120, 12'd120, 12'd200);
        tick();
        exp_drop++;
        check("drop_after_move", int'(drop_cnt), exp_drop);
`endif
        touch_in = 1'b0;
        tick(6);
        exp_drop++;
        check("drop_after_release", int'(drop_cnt), exp_drop);
        check("held_valid", int'(evt_valid), 1);
        check("held_type", int'(evt_type), 1);
        check("held_x", int'(evt_x), 103);
        evt_ready = 1'b1;
        tick();
        check("single_transfer", int'(evt_valid), 0);
        tick(2);
        check("sb_drain_bp", exp_q.size(), 0);

        // Forced drops until saturation
        evt_ready = 1'b0;
        touch_in  = 1'b1;
        tick(6);
        push(2'b01, 12'd103, 12'd200);
        win4(12'd100, 12'd102, 12'd104, 12'd106, 12'd200);
        tick();
        for (int i = 0; i < 150; i++) begin
            touch_in = 1'b0;
            tick(6);
            touch_in = 1'b1;
            tick(6);
            win4(12'd100, 12'd102, 12'd104, 12'd106, 12'd200);
            tick();
            exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
            if (i == 0) check("drop_count_step", int'(drop_cnt), exp_drop);
        end
        check("drop_saturate", int'(drop_cnt), 255);
        evt_ready = 1'b1;
        tick(2);
        check("sb_drain_drops", exp_q.size(), 0);

        // Reset mid-operation discards a pending RELEASE
        evt_ready = 1'b0;
        touch_in  = 1'b0;
        tick(6);
        check("pending_before_reset", int'(evt_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(evt_valid), 0);
        check("midrst_type", int'(evt_type), 0);
        check("midrst_drop", int'(drop_cnt), 0);
        evt_ready = 1'b1;
        tick(3);
        check("sb_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
